// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared mode encodings and parameter defaults for the multi-channel DDS
package dds_pkg;

    typedef enum logic [1:0] {
        MODE_FREQ = 2'd0,
        MODE_AMP  = 2'd1,
        MODE_PHS  = 2'd2,
        MODE_HOLD = 2'd3
    } dds_mode_t;

    localparam int NCH_DEF      = 2;
    localparam int ACC_W_DEF    = 24;
    localparam int ADDR_W_DEF   = 8;
    localparam int DATA_W_DEF   = 8;
    localparam int AMP_W_DEF    = 8;
    localparam int FTW_INIT_DEF = 336;
    localparam int FTW_STEP_DEF = 168;
    localparam int FTW_MIN_DEF  = 168;
    localparam int AMP_INIT_DEF = 255;
    localparam int AMP_STEP_DEF = 10;
    localparam int PHS_STEP_DEF = 16;

endpackage

// File: rtl/dds_multi_ctrl_if.sv
// rtl/dds_multi_ctrl_if.sv - key/control inputs, ROM port and wave output of the DDS block
interface dds_multi_ctrl_if #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = (NCH > 1) ? $clog2(NCH) : 1
);
    logic [SEL_W-1:0]        ch_sel;
    logic [1:0]              mode;
    logic                    key_inc;
    logic                    key_dec;
    logic                    sync_clr;
    logic [NCH*DATA_W-1:0]   rom_data;
    logic [NCH*ADDR_W-1:0]   addr;
    logic [NCH*DATA_W-1:0]   wave_out;
    logic                    wave_vld;

    modport master (
        output ch_sel, mode, key_inc, key_dec, sync_clr, rom_data,
        input  addr, wave_out, wave_vld
    );

    modport slave (
        input  ch_sel, mode, key_inc, key_dec, sync_clr, rom_data,
        output addr, wave_out, wave_vld
    );
endinterface

// File: rtl/dds_chan.sv
// rtl/dds_chan.sv - one DDS channel: tuning/amplitude/phase registers, accumulator, address and scaling stages
module dds_chan
    import dds_pkg::*;
#(
    parameter int ACC_W    = ACC_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int AMP_W    = AMP_W_DEF,
    parameter int FTW_INIT = FTW_INIT_DEF,
    parameter int FTW_STEP = FTW_STEP_DEF,
    parameter int FTW_MIN  = FTW_MIN_DEF,
    parameter int AMP_INIT = AMP_INIT_DEF,
    parameter int AMP_STEP = AMP_STEP_DEF,
    parameter int PHS_STEP = PHS_STEP_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              key_inc,
    input  logic              key_dec,
    input  dds_mode_t         mode,
    input  logic              sync_clr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wave_out
);
    localparam logic [ACC_W:0] FTW_MAX     = {1'b0, {ACC_W{1'b1}}};
    localparam logic [ACC_W:0] FTW_STEP_X  = (ACC_W+1)'(FTW_STEP);
    localparam logic [ACC_W:0] FTW_DEC_LIM = (ACC_W+1)'(FTW_MIN + FTW_STEP);
    localparam logic [AMP_W:0] AMP_MAX     = {1'b0, {AMP_W{1'b1}}};
    localparam logic [AMP_W:0] AMP_STEP_X  = (AMP_W+1)'(AMP_STEP);

    logic [ACC_W-1:0]        ftw, ftw_nxt, acc;
    logic [AMP_W-1:0]        amp, amp_nxt;
    logic [ADDR_W-1:0]       phs, phs_nxt;
    logic [ACC_W:0]          ftw_up;
    logic [AMP_W:0]          amp_up;
    logic [DATA_W+AMP_W-1:0] prod;

    // One extra bit on the sums so the saturating compare sees the carry.
    assign ftw_up = {1'b0, ftw} + FTW_STEP_X;
    assign amp_up = {1'b0, amp} + AMP_STEP_X;
    assign prod   = (DATA_W+AMP_W)'(rom_data) * (DATA_W+AMP_W)'(amp);

    always_comb begin
        ftw_nxt = ftw;
        amp_nxt = amp;
        phs_nxt = phs;
        if (key_inc) begin
            case (mode)
                MODE_FREQ: ftw_nxt = (ftw_up > FTW_MAX) ? {ACC_W{1'b1}} : ftw_up[ACC_W-1:0];
                MODE_AMP:  amp_nxt = (amp_up > AMP_MAX) ? {AMP_W{1'b1}} : amp_up[AMP_W-1:0];
                MODE_PHS:  phs_nxt = phs + ADDR_W'(PHS_STEP);
                default:   ;
            endcase
        end else if (key_dec) begin
            case (mode)
                MODE_FREQ: ftw_nxt = ({1'b0, ftw} < FTW_DEC_LIM) ? ACC_W'(FTW_MIN) : ftw - ACC_W'(FTW_STEP);
                MODE_AMP:  amp_nxt = ({1'b0, amp} < AMP_STEP_X) ? '0 : amp - AMP_W'(AMP_STEP);
                MODE_PHS:  phs_nxt = phs - ADDR_W'(PHS_STEP);
                default:   ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ftw      <= ACC_W'(FTW_INIT);
            amp      <= AMP_W'(AMP_INIT);
            phs      <= '0;
            acc      <= '0;
            addr     <= '0;
            wave_out <= '0;
        end else begin
            ftw      <= ftw_nxt;
            amp      <= amp_nxt;
            phs      <= phs_nxt;
            // Accumulator is never reloaded on a tuning change, keeping phase continuous.
            acc      <= sync_clr ? '0 : acc + ftw;
            addr     <= acc[ACC_W-1 -: ADDR_W] + phs;
            wave_out <= DATA_W'(prod >> AMP_W);
        end
    end

endmodule

// File: rtl/dds_multi_ctrl.sv
// rtl/dds_multi_ctrl.sv - multi-channel DDS controller top: key decode, channel array and output-valid tracking
module dds_multi_ctrl
    import dds_pkg::*;
#(
    parameter int NCH      = NCH_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int AMP_W    = AMP_W_DEF,
    parameter int FTW_INIT = FTW_INIT_DEF,
    parameter int FTW_STEP = FTW_STEP_DEF,
    parameter int FTW_MIN  = FTW_MIN_DEF,
    parameter int AMP_INIT = AMP_INIT_DEF,
    parameter int AMP_STEP = AMP_STEP_DEF,
    parameter int PHS_STEP = PHS_STEP_DEF
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    dds_multi_ctrl_if.slave bus
);
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic       key_ok;
    logic [1:0] vld_cnt;

    // Simultaneous inc and dec cancel out; out-of-range ch_sel matches no channel.
    assign key_ok = bus.key_inc ^ bus.key_dec;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic sel;
        assign sel = key_ok && (bus.ch_sel == SEL_W'(k));

        dds_chan #(
            .ACC_W    (ACC_W),
            .ADDR_W   (ADDR_W),
            .DATA_W   (DATA_W),
            .AMP_W    (AMP_W),
            .FTW_INIT (FTW_INIT),
            .FTW_STEP (FTW_STEP),
            .FTW_MIN  (FTW_MIN),
            .AMP_INIT (AMP_INIT),
            .AMP_STEP (AMP_STEP),
            .PHS_STEP (PHS_STEP)
        ) u_chan (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .key_inc   (sel & bus.key_inc),
            .key_dec   (sel & bus.key_dec),
            .mode      (dds_mode_t'(bus.mode)),
            .sync_clr  (bus.sync_clr),
            .rom_data  (bus.rom_data[k*DATA_W +: DATA_W]),
            .addr      (bus.addr[k*ADDR_W +: ADDR_W]),
            .wave_out  (bus.wave_out[k*DATA_W +: DATA_W])
        );
    end

    // The first clock after reset and a sync_clr edge both start a two-cycle refill.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_cnt      <= 2'd0;
            bus.wave_vld <= 1'b0;
        end else if (bus.sync_clr) begin
            vld_cnt      <= 2'd1;
            bus.wave_vld <= 1'b0;
        end else begin
            if (vld_cnt != 2'd3) vld_cnt <= vld_cnt + 2'd1;
            bus.wave_vld <= (vld_cnt >= 2'd2);
        end
    end

endmodule
